// File: rtl/adc_spi_pkg.sv
// Shared constants and types for the SPI ADC responder.
package adc_spi_pkg;
  localparam int NUM_CH     = 8;
  localparam int SAMPLE_W   = 12;
  localparam int ADDR_W     = 3;
  localparam int LEAD_ZEROS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/adc_spi_sync_edge.sv
// Multi-flop synchronizer with a history flop producing level and single-cycle edge pulses.
module adc_spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~hist_q;
  assign fall = ~lvl & hist_q;
endmodule

// File: rtl/adc_spi_responder.sv
// Device-side model of an 8-channel 12-bit SPI ADC with a host-loaded sample file.
// Define ADC_RESP_AUTOINC_EN to bump each channel's sample after every frame that carried it.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FRAME_BITS   = 16,
  parameter int ADDR_LSB_POS = 4,
  parameter int INC_STEP     = 1
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        adc_cs_n,
  input  logic        adc_sck,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic        wr_en,
  input  logic [2:0]  wr_ch,
  input  logic [11:0] wr_data,
  output logic        frame_done,
  output logic [2:0]  frame_ch,
  output logic        frame_err
);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(ADDR_LSB_POS - 2);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_LSB_POS);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic din_lvl, din_rise_unused, din_fall_unused;

  adc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk_50), .rst(rst), .d(adc_cs_n), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  adc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck (
    .clk(clk_50), .rst(rst), .d(adc_sck), .lvl(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  adc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk(clk_50), .rst(rst), .d(din), .lvl(din_lvl), .rise(din_rise_unused), .fall(din_fall_unused));

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0]     cur_ch_q, cur_ch_d, addr_q, addr_d, next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]     frame_ch_q, frame_ch_d;
  logic                  dout_q, dout_d, dout_oe_q, dout_oe_d;
  logic                  frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  sample_t               sample_q [NUM_CH];
  sample_t               sample_d [NUM_CH];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    cur_ch_d     = cur_ch_q;
    addr_d       = addr_q;
    next_addr_d  = next_addr_q;
    dout_d       = dout_q;
    dout_oe_d    = dout_oe_q;
    frame_done_d = 1'b0;
    frame_ch_d   = frame_ch_q;
    frame_err_d  = 1'b0;
    sample_d     = sample_q;

    case (state_q)
      IDLE: begin
        dout_d    = 1'b0;
        dout_oe_d = 1'b0;
        bit_cnt_d = '0;
        // Raise OE together with the LOAD transition so it tracks cs_n at the sck latency.
        if (cs_fall) begin
          state_d   = LOAD;
          dout_oe_d = 1'b1;
        end
      end
      LOAD: begin
        bit_cnt_d = '0;
        dout_d    = 1'b0;
        if (cs_rise) begin
          state_d   = IDLE;
          dout_oe_d = 1'b0;
        end else begin
          shift_d   = {{LEAD_ZEROS{1'b0}}, sample_q[addr_q]};
          cur_ch_d  = addr_q;
          dout_oe_d = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CNT_END) begin
          frame_done_d = 1'b1;
          frame_ch_d   = cur_ch_q;
          addr_d       = next_addr_q;
          bit_cnt_d    = '0;
          if (cs_lvl) begin
            state_d   = IDLE;
            dout_oe_d = 1'b0;
            dout_d    = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end else if (cs_rise) begin
          state_d     = IDLE;
          dout_oe_d   = 1'b0;
          dout_d      = 1'b0;
          bit_cnt_d   = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else begin
          if (sck_rise && bit_cnt_q >= ADDR_FIRST && bit_cnt_q <= ADDR_LAST)
            next_addr_d = {next_addr_q[ADDR_W-2:0], din_lvl};
          if (sck_fall) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            dout_d    = shift_q[FRAME_BITS-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ADC_RESP_AUTOINC_EN
    if (frame_done_d) sample_d[cur_ch_q] = sample_q[cur_ch_q] + sample_t'(INC_STEP);
`else
    sample_d[0] = sample_d[0] | (sample_t'(INC_STEP) & '0);
`endif
    // Host write is applied last so it overrides any increment of the same channel.
    if (wr_en) sample_d[wr_ch] = wr_data;
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      cur_ch_q     <= '0;
      addr_q       <= '0;
      next_addr_q  <= '0;
      dout_q       <= 1'b0;
      dout_oe_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ch_q   <= '0;
      frame_err_q  <= 1'b0;
      sample_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      cur_ch_q     <= cur_ch_d;
      addr_q       <= addr_d;
      next_addr_q  <= next_addr_d;
      dout_q       <= dout_d;
      dout_oe_q    <= dout_oe_d;
      frame_done_q <= frame_done_d;
      frame_ch_q   <= frame_ch_d;
      frame_err_q  <= frame_err_d;
      sample_q     <= sample_d;
    end
  end

  assign dout       = dout_q;
  assign dout_oe    = dout_oe_q;
  assign frame_done = frame_done_q;
  assign frame_ch   = frame_ch_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: drives SPI frames, scoreboards frame data against expected channel samples.
module tb_adc_spi_responder;
  logic        clk_50 = 1'b0;
  logic        rst, adc_cs_n, adc_sck, din, wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic        dout, dout_oe, frame_done, frame_err;
  logic [2:0]  frame_ch;

  adc_spi_responder dut (
    .clk_50(clk_50), .rst(rst), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .din(din),
    .dout(dout), .dout_oe(dout_oe), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .frame_done(frame_done), .frame_ch(frame_ch), .frame_err(frame_err));

  always #10 clk_50 = ~clk_50;

  typedef struct { logic [2:0] ch; logic [11:0] data; } exp_t;
  typedef struct { logic [2:0] addr; bit hold; logic [2:0] ch; logic [11:0] data; } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[5];
  int          n_cmp = 0, n_fail = 0, n_done = 0, n_err = 0, n_gap = 0, cs_low_cnt = 0;
  logic [15:0] cap_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: each frame_done consumes the oldest expected frame.
  always @(negedge clk_50) begin
    if (frame_done === 1'b1) begin
      n_done++;
      chk("frame_done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_ch", 32'(frame_ch), 32'(e.ch));
        chk("frame_data", 32'(cap_word), 32'({4'b0000, e.data}));
      end
    end
    if (frame_err === 1'b1) n_err++;
    if (adc_cs_n === 1'b0) cs_low_cnt++;
    else cs_low_cnt = 0;
    if (cs_low_cnt > 6 && dout_oe !== 1'b1) n_gap++;
  end

  task automatic host_wr(input logic [2:0] ch, input logic [11:0] d);
    wr_ch = ch; wr_data = d; wr_en = 1'b1;
    @(negedge clk_50);
    wr_en = 1'b0;
  endtask

  // sck half period of 4 clk_50 cycles; dout captured just before each falling edge.
  task automatic run_frame(input logic [2:0] a, input int nbits, input bit raise_cs,
                           input int wr_bit, input logic [2:0] wc, input logic [11:0] wd);
    logic [15:0] w;
    w = {2'b00, a, 11'b0};
    if (adc_cs_n) begin
      adc_cs_n = 1'b0;
      repeat (6) @(negedge clk_50);
    end
    for (int p = 1; p <= nbits; p++) begin
      cap_word[16-p] = dout;
      adc_sck = 1'b0;
      din = (p <= 15) ? w[15-p] : 1'b0;
      if (p == wr_bit) begin
        host_wr(wc, wd);
        repeat (3) @(negedge clk_50);
      end else begin
        repeat (4) @(negedge clk_50);
      end
      adc_sck = 1'b1;
      repeat (4) @(negedge clk_50);
    end
    if (raise_cs) begin
      adc_cs_n = 1'b1;
      repeat (8) @(negedge clk_50);
    end
  endtask

  task automatic frame_exp(input logic [2:0] a, input bit hold, input logic [2:0] ch,
                           input logic [11:0] d, input int wr_bit, input logic [11:0] wd);
    exp_q.push_back('{ch, d});
    run_frame(a, 16, !hold, wr_bit, 3'd5, wd);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_dout_oe"}, 32'(dout_oe), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_ch"}, 32'(frame_ch), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int ne, nd;
    rst = 1'b1; adc_cs_n = 1'b1; adc_sck = 1'b1; din = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    repeat (3) @(negedge clk_50);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk_50);

`ifndef ADC_RESP_AUTOINC_EN
    host_wr(3'd5, 12'd1118);
    host_wr(3'd6, 12'd1998);
    host_wr(3'd7, 12'd3802);

    tbl[0] = '{3'd5, 1'b0, 3'd0, 12'd0};
    tbl[1] = '{3'd6, 1'b0, 3'd5, 12'd1118};
    tbl[2] = '{3'd7, 1'b1, 3'd6, 12'd1998};
    tbl[3] = '{3'd5, 1'b1, 3'd7, 12'd3802};
    tbl[4] = '{3'd7, 1'b0, 3'd5, 12'd1118};
    for (int i = 0; i < 5; i++) frame_exp(tbl[i].addr, tbl[i].hold, tbl[i].ch, tbl[i].data, 0, '0);
    chk("done_count_table", 32'(n_done), 32'd5);
    chk("oe_gap_back_to_back", 32'(n_gap), 32'd0);

    // Abort after 7 sck cycles: address 3 must not be latched.
    ne = n_err; nd = n_done;
    run_frame(3'd3, 7, 1'b1, 0, '0, '0);
    chk("abort_err_pulses", 32'(n_err - ne), 32'd1);
    chk("abort_dout_oe", 32'(dout_oe), 32'd0);
    chk("abort_no_done", 32'(n_done - nd), 32'd0);
    frame_exp(3'd5, 1'b0, 3'd7, 12'd3802, 0, '0);

    // Host write to ch5 while ch5 is in flight.
    frame_exp(3'd6, 1'b0, 3'd5, 12'd1118, 8, 12'hABC);
    frame_exp(3'd5, 1'b0, 3'd6, 12'd1998, 0, '0);
    frame_exp(3'd6, 1'b0, 3'd5, 12'hABC, 0, '0);

    // Reset mid-frame clears outputs, address and sample file.
    run_frame(3'd2, 5, 1'b0, 0, '0, '0);
    rst = 1'b1;
    @(negedge clk_50);
    chk_outputs_zero("midframe_rst");
    adc_cs_n = 1'b1; adc_sck = 1'b1; din = 1'b0;
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    repeat (4) @(negedge clk_50);
    frame_exp(3'd5, 1'b0, 3'd0, 12'd0, 0, '0);
    frame_exp(3'd0, 1'b0, 3'd5, 12'd0, 0, '0);
`else
    host_wr(3'd3, 12'd4095);
    frame_exp(3'd3, 1'b0, 3'd0, 12'd0, 0, '0);
    frame_exp(3'd3, 1'b0, 3'd3, 12'd4095, 0, '0);
    frame_exp(3'd3, 1'b0, 3'd3, 12'd0, 0, '0);
`endif

    repeat (10) @(negedge clk_50);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
